// File: rtl/dff_bank_wr_arb.sv
// Round-robin write arbiter for a bank of enable-gated registers: grants one
// requester at a time, drives the shared d bus and pulses a single en bit.
module dff_bank_wr_arb #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int NREG = 4,
    parameter int AW   = 2
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   wr_addr,
    input  logic [NREQ*DW-1:0]   wr_data,
    output logic [NREQ-1:0]      gnt,
    output logic [NREG-1:0]      en,
    output logic [DW-1:0]        d,
    output logic                 err,
    output logic                 busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        COOL  = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   ptr, ptr_nx;
    logic [NREQ-1:0] gnt_nx;
    logic [NREG-1:0] en_nx;
    logic [DW-1:0]   d_nx;
    logic            err_nx;
    logic            busy_nx;
    logic            found;
    logic [PW-1:0]   win;
    logic [AW-1:0]   addr_w;

    // Every output is computed here one cycle ahead and registered below, so
    // the WRITE-cycle outputs appear right after the edge that picks a winner.
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        gnt_nx   = '0;
        en_nx    = '0;
        d_nx     = d;
        err_nx   = 1'b0;
        found    = 1'b0;
        win      = '0;
        addr_w   = '0;

        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end

        case (state)
            IDLE: begin
                if (found) begin
                    state_nx    = WRITE;
                    ptr_nx      = (int'(win) == NREQ - 1) ? '0 : win + PW'(1);
                    gnt_nx[win] = 1'b1;
                    addr_w      = wr_addr[int'(win)*AW +: AW];
                    d_nx        = wr_data[int'(win)*DW +: DW];
                    err_nx      = (int'(addr_w) >= NREG);
                    for (int r = 0; r < NREG; r++) begin
                        if (int'(addr_w) == r) begin
                            en_nx[r] = 1'b1;
                        end
                    end
                end
            end
            WRITE:   state_nx = COOL;
            COOL:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state <= IDLE;
            ptr   <= '0;
            gnt   <= '0;
            en    <= '0;
            d     <= '0;
            err   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            gnt   <= gnt_nx;
            en    <= en_nx;
            d     <= d_nx;
            err   <= err_nx;
            busy  <= busy_nx;
        end
    end

endmodule
